// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_DEPTH  = 32;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      DRAIN,
      DONE
   } rf_state_t;

endpackage

// File: rtl/rf_dump_buf.sv
// Two-entry capture/drain buffer: loads one or two read-port words at once,
// then presents them oldest-first and retires one per pop.
module rf_dump_buf
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W
)
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              i_load,
   input  logic              i_load_b,
   input  logic [DATA_W-1:0] i_data_a,
   input  logic [DATA_W-1:0] i_data_b,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_last
);

   logic [DATA_W-1:0] r_data [2];
   logic [1:0]        r_valid;

   logic [DATA_W-1:0] w_in [2];
   logic [1:0]        w_in_valid;
   logic [1:0]        w_pop_sel;

   assign w_in[0]    = i_data_a;
   assign w_in[1]    = i_data_b;
   assign w_in_valid = {i_load_b, 1'b1};

   // Entry 0 always drains before entry 1.
   assign w_pop_sel  = {i_pop & ~r_valid[0] & r_valid[1], i_pop & r_valid[0]};

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_data[i]  <= '0;
            r_valid[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i_load) begin
               r_data[i]  <= w_in[i];
               r_valid[i] <= w_in_valid[i];
            end else if (w_pop_sel[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign o_data  = r_valid[0] ? r_data[0] : r_data[1];
   assign o_valid = r_valid[0] | r_valid[1];
   assign o_last  = r_valid[0] ^ r_valid[1];

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a wrapping register range, fetching two registers per read issue,
// and streams the words out on a valid/ready interface.
module rf_dump_reader
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
)
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [ADDR_W:0]   Count,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] ReadA,
   output logic              ReadAEn,
   output logic [ADDR_W-1:0] ReadB,
   output logic              ReadBEn,
   input  logic [DATA_W-1:0] RfDataA,
   input  logic [DATA_W-1:0] RfDataB,
   output logic [DATA_W-1:0] DataOut,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              OutLast
);

   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(1 << ADDR_W);

   rf_state_t         r_state;
   rf_state_t         w_state_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_rem;
   logic [ADDR_W-1:0] r_read_a;
   logic [ADDR_W-1:0] r_read_b;
   logic              r_b_issued;

   logic [ADDR_W:0]   w_count_clamped;
   logic              w_issue;
   logic              w_issue_b;
   logic [ADDR_W-1:0] w_ptr_inc;
   logic [ADDR_W-1:0] w_step_ptr;
   logic [ADDR_W:0]   w_step_rem;
   logic              w_fire;
   logic [DATA_W-1:0] w_buf_data;
   logic              w_buf_valid;
   logic              w_buf_last;

   assign w_count_clamped = (Count > L_DEPTH) ? L_DEPTH : Count;
   assign w_issue         = (r_state == ISSUE);
   assign w_issue_b       = w_issue && (r_rem >= (ADDR_W+1)'(2));
   assign w_ptr_inc       = r_ptr + ADDR_W'(1);
   assign w_step_ptr      = r_b_issued ? ADDR_W'(2) : ADDR_W'(1);
   assign w_step_rem      = {1'b0, w_step_ptr};

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_rem      <= '0;
         r_read_a   <= '0;
         r_read_b   <= '0;
         r_b_issued <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            IDLE: begin
               if (Start) begin
                  r_ptr <= BaseAddr;
                  r_rem <= w_count_clamped;
               end
            end
            ISSUE: begin
               r_read_a   <= r_ptr;
               r_b_issued <= w_issue_b;
               if (w_issue_b) begin
                  r_read_b <= w_ptr_inc;
               end
            end
            CAPTURE: begin
               r_ptr <= r_ptr + w_step_ptr;
               r_rem <= r_rem - w_step_rem;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_state_next = (w_count_clamped == '0) ? DONE : ISSUE;
            end
         end
         ISSUE:   w_state_next = CAPTURE;
         CAPTURE: w_state_next = DRAIN;
         DRAIN: begin
            // Leave on the handshake of the final buffered word, not a cycle later.
            if (!w_buf_valid || (w_fire && w_buf_last)) begin
               w_state_next = (r_rem == '0) ? DONE : ISSUE;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   rf_dump_buf #(
      .DATA_W   (DATA_W)
   ) u_buf (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .i_load   (r_state == CAPTURE),
      .i_load_b (r_b_issued),
      .i_data_a (RfDataA),
      .i_data_b (RfDataB),
      .i_pop    (w_fire),
      .o_data   (w_buf_data),
      .o_valid  (w_buf_valid),
      .o_last   (w_buf_last)
   );

   assign Busy     = (r_state != IDLE);
   assign Done     = (r_state == DONE);
   assign ReadAEn  = w_issue;
   assign ReadA    = w_issue ? r_ptr : r_read_a;
   assign ReadBEn  = w_issue_b;
   assign ReadB    = w_issue_b ? w_ptr_inc : r_read_b;
   assign OutValid = (r_state == DRAIN) && w_buf_valid;
   assign w_fire   = OutValid && OutReady;
   assign DataOut  = OutValid ? w_buf_data : '0;
   assign OutLast  = OutValid && w_buf_last && (r_rem == '0);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader with a behavioural synchronous register file.
module tb_rf_dump_reader;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } word_t;

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      logic       ben;
   } issue_t;

   logic        clk;
   logic        Rst_n;
   logic        Start;
   logic [4:0]  BaseAddr;
   logic [5:0]  Count;
   logic        Busy;
   logic        Done;
   logic [4:0]  ReadA;
   logic        ReadAEn;
   logic [4:0]  ReadB;
   logic        ReadBEn;
   logic [31:0] RfDataA;
   logic [31:0] RfDataB;
   logic [31:0] DataOut;
   logic        OutValid;
   logic        OutReady;
   logic        OutLast;

   logic [31:0] rf_mem [32];

   word_t  exp_q[$];
   issue_t issue_log[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int valid_cycles = 0;
   int first_valid_cyc = -1;
   int words_seen = 0;

   logic        toggle_en = 1'b0;
   logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   rf_dump_reader dut (
      .Clk      (clk),
      .Rst_n    (Rst_n),
      .Start    (Start),
      .BaseAddr (BaseAddr),
      .Count    (Count),
      .Busy     (Busy),
      .Done     (Done),
      .ReadA    (ReadA),
      .ReadAEn  (ReadAEn),
      .ReadB    (ReadB),
      .ReadBEn  (ReadBEn),
      .RfDataA  (RfDataA),
      .RfDataB  (RfDataB),
      .DataOut  (DataOut),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .OutLast  (OutLast)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Register file model: 1-cycle synchronous read, data holds when not enabled.
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i);
      RfDataA = '0;
      RfDataB = '0;
   end

   always @(posedge clk) begin
      if (ReadAEn) RfDataA <= rf_mem[ReadA];
      if (ReadBEn) RfDataB <= rf_mem[ReadB];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // OutReady pattern driver for stalled dumps.
   initial begin
      int pidx;
      pidx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) begin
            OutReady = pat[pidx];
            pidx = (pidx + 1) % 4;
         end else begin
            pidx = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake and watches stall stability.
   initial begin
      logic        stall_prev;
      logic [31:0] prev_data;
      logic        prev_last;
      word_t       w;
      stall_prev = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (ReadAEn) issue_log.push_back('{a: ReadA, b: ReadB, ben: ReadBEn});
         if (OutValid) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (stall_prev && Rst_n) begin
            chk("stall_valid_held", {31'd0, OutValid}, 32'd1);
            chk("stall_data_stable", DataOut, prev_data);
            chk("stall_last_stable", {31'd0, OutLast}, {31'd0, prev_last});
         end
         if (OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0d expected no word", DataOut);
            end else begin
               w = exp_q.pop_front();
               chk("word_data", DataOut, w.data);
               chk("word_last", {31'd0, OutLast}, {31'd0, w.last});
               words_seen++;
            end
         end
         if (Done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = Rst_n && OutValid && !OutReady;
         prev_data  = DataOut;
         prev_last  = OutLast;
      end
   end

   task automatic run_dump(input int base, input int count, input bit poke, input bit toggle,
                           output int s);
      issue_log.delete();
      done_cnt        = 0;
      done_cyc        = -1;
      valid_cycles    = 0;
      first_valid_cyc = -1;
      words_seen      = 0;
      for (int i = 0; i < count; i++)
         exp_q.push_back('{data: 32'((base + i) % 32), last: (i == count - 1)});
      $display("dump base=%0d count=%0d stall=%0d", base, count, toggle);
      BaseAddr  = 5'(base);
      Count     = 6'(count);
      Start     = 1'b1;
      toggle_en = toggle;
      @(posedge clk);
      #1;
      Start = 1'b0;
      s = cyc;
      for (int i = 0; i < 400 && done_cnt == 0; i++) begin
         @(posedge clk);
         #1;
         if (poke && i == 4) begin
            chk("busy_at_poke", {31'd0, Busy}, 32'd1);
            BaseAddr = 5'd20;
            Count    = 6'd5;
            Start    = 1'b1;
         end else if (poke && i == 5) begin
            Start = 1'b0;
         end
      end
      if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
      toggle_en = 1'b0;
      OutReady  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("words_left", 32'(exp_q.size()), 32'd0);
      chk("busy_after", {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      int s;
      int ben_cnt;
      Rst_n    = 1'b0;
      Start    = 1'b0;
      BaseAddr = '0;
      Count    = '0;
      OutReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_valid", {31'd0, OutValid}, 32'd0);
      chk("rst_aen", {31'd0, ReadAEn}, 32'd0);
      chk("rst_data", DataOut, 32'd0);
      @(posedge clk);
      #1;
      Rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full 32-entry dump: 16 dual issues, 2 words per 4 cycles.
      run_dump(0, 32, 1'b0, 1'b0, s);
      chk("full_first_valid_cyc", 32'(first_valid_cyc - s), 32'd2);
      chk("full_done_cyc", 32'(done_cyc - s), 32'd64);
      chk("full_issues", 32'(issue_log.size()), 32'd16);
      ben_cnt = 0;
      foreach (issue_log[i]) if (issue_log[i].ben) ben_cnt++;
      chk("full_ben_issues", 32'(ben_cnt), 32'd16);

      // Odd count: second issue is single-port.
      run_dump(5, 3, 1'b0, 1'b0, s);
      chk("odd_issues", 32'(issue_log.size()), 32'd2);
      if (issue_log.size() >= 2) begin
         chk("odd_first_b", {27'd0, issue_log[0].b}, 32'd6);
         chk("odd_second_a", {27'd0, issue_log[1].a}, 32'd7);
         chk("odd_second_ben", {31'd0, issue_log[1].ben}, 32'd0);
      end

      // Address wrap 31 -> 0.
      run_dump(30, 4, 1'b0, 1'b0, s);
      chk("wrap_issues", 32'(issue_log.size()), 32'd2);
      if (issue_log.size() >= 2) begin
         chk("wrap_second_a", {27'd0, issue_log[1].a}, 32'd0);
         chk("wrap_second_b", {27'd0, issue_log[1].b}, 32'd1);
         chk("wrap_second_ben", {31'd0, issue_log[1].ben}, 32'd1);
      end

      // Zero count: Start sampled at one edge, DONE occupies the next cycle.
      run_dump(9, 0, 1'b0, 1'b0, s);
      chk("zero_done_cyc", 32'(done_cyc - s), 32'd0);
      chk("zero_valid_cycles", 32'(valid_cycles), 32'd0);
      chk("zero_issues", 32'(issue_log.size()), 32'd0);

      // Backpressure plus an ignored Start while busy.
      run_dump(12, 6, 1'b1, 1'b1, s);
      chk("stall_words", 32'(words_seen), 32'd6);

      // Reset during DRAIN of a full dump.
      done_cnt   = 0;
      words_seen = 0;
      for (int i = 0; i < 32; i++) exp_q.push_back('{data: 32'(i), last: (i == 31)});
      $display("dump base=0 count=32 reset-abort");
      BaseAddr = 5'd0;
      Count    = 6'd32;
      Start    = 1'b1;
      @(posedge clk);
      #1;
      Start = 1'b0;
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (OutValid && words_seen >= 3) hit = 1'b1;
         end
         if (!hit) chk("abort_drain_timeout", 32'd0, 32'd1);
      end
      Rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      chk("abort_done", {31'd0, Done}, 32'd0);
      chk("abort_valid", {31'd0, OutValid}, 32'd0);
      chk("abort_last", {31'd0, OutLast}, 32'd0);
      chk("abort_data", DataOut, 32'd0);
      chk("abort_ren", {30'd0, ReadAEn, ReadBEn}, 32'd0);
      chk("abort_addr", {22'd0, ReadA, ReadB}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      Rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 32'd0);

      run_dump(0, 2, 1'b0, 1'b0, s);
      chk("post_reset_words", 32'(words_seen), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
